mdu_sequencer: RTL and testbench

- Control FSM for the CPU's iterative multiply/divide unit (MDU). Accepts one mul/div issue from decode and sequences the MDU datapath: operand load, then ITER step cycles.
- Arbitrates the single register-file write port between pipeline writeback and the MDU result.
- Generates the pipeline stall for structural hazards and for RAW hazards on the pending MDU destination.

---
 rtl/mdu_sequencer.sv | 156 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: control FSM for the iterative multiply/divide unit.
// Accepts one mul/div issue, sequences operand load and ITER step cycles,
// arbitrates the single register-file write port between pipeline writeback
// and the MDU result, and raises the pipeline stall for structural and RAW
// hazards on the pending MDU destination.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   start_i                      CPU run enable (gates new issues)
//   issue_valid_i/op_i/rd_i      MDU instruction from decode
//   hz_rs_i, hz_rt_i             sources of the instruction in decode
//   wb_valid_i, wb_rd_i          pipeline writeback port request
//   issue_ready_o                issue accepted with issue_valid_i
//   dp_load_o, dp_step_o, dp_op_o  MDU datapath controls
//   stall_o                      freeze PC, IF/ID and decode
//   rf_we_o, rf_addr_o, rf_sel_mdu_o  register-file write port
//   busy_o                       operation in flight
//
// state | meaning
// IDLE  | waiting for an issue
// LOAD  | datapath latches operands, step counter loaded
// RUN   | one datapath iteration per cycle, counter runs down to 0
// WRITE | result waits for the write port (at most MAX_WAIT yields)
module mdu_sequencer #(
  parameter int ITER     = 32,
  parameter int MAX_WAIT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       issue_valid_i,
  input  logic       issue_op_i,
  input  logic [4:0] issue_rd_i,
  input  logic [4:0] hz_rs_i,
  input  logic [4:0] hz_rt_i,
  input  logic       wb_valid_i,
  input  logic [4:0] wb_rd_i,
  output logic       issue_ready_o,
  output logic       dp_load_o,
  output logic       dp_step_o,
  output logic       dp_op_o,
  output logic       stall_o,
  output logic       rf_we_o,
  output logic [4:0] rf_addr_o,
  output logic       rf_sel_mdu_o,
  output logic       busy_o
);

  localparam int CW = $clog2(ITER);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ITER - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          op_q, op_d;
  logic [4:0]    rd_q, rd_d;

  logic       ready_c, load_c, step_c, forced_c, we_c, sel_c;
  logic [4:0] addr_c;
  logic       busy_c, raw_c;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      op_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wcnt_d   = '0;
    op_d     = op_q;
    rd_d     = rd_q;
    ready_c  = 1'b0;
    load_c   = 1'b0;
    step_c   = 1'b0;
    forced_c = 1'b0;
    // Writeback owns the port unless the MDU result takes it in WRITE.
    we_c     = wb_valid_i;
    addr_c   = wb_rd_i;
    sel_c    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = start_i;
        if (issue_valid_i && start_i) begin
          op_d    = issue_op_i;
          rd_d    = issue_rd_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_c  = 1'b1;
        cnt_d   = CNT_LOAD;
        state_d = RUN;
      end
      RUN: begin
        step_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITE: begin
        if (wb_valid_i && (wcnt_q < WAIT_MAX)) begin
          wcnt_d = wcnt_q + 1'b1;
        end else begin
          // Either the port is free, or writeback has had its quota and is
          // held off by the stall while the MDU result is written.
          we_c     = (rd_q != 5'd0);
          addr_c   = rd_q;
          sel_c    = 1'b1;
          forced_c = wb_valid_i;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_c = (state_q != IDLE);
  // r0 is never written, so it can never be a pending hazard.
  assign raw_c  = busy_c && (rd_q != 5'd0) &&
                  ((hz_rs_i == rd_q) || (hz_rt_i == rd_q));

  // The pass-through paths are gated so every output reads 0 during reset.
  assign issue_ready_o = rst_i & ready_c;
  assign dp_load_o     = load_c;
  assign dp_step_o     = step_c;
  assign dp_op_o       = op_q;
  assign stall_o       = rst_i & ((busy_c & issue_valid_i) | raw_c | forced_c);
  assign rf_we_o       = rst_i & we_c;
  assign rf_addr_o     = rst_i ? addr_c : 5'd0;
  assign rf_sel_mdu_o  = sel_c;
  assign busy_o        = busy_c;

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       issue_valid_i;
  logic       issue_op_i;
  logic [4:0] issue_rd_i;
  logic [4:0] hz_rs_i;
  logic [4:0] hz_rt_i;
  logic       wb_valid_i;
  logic [4:0] wb_rd_i;
  logic       issue_ready_o;
  logic       dp_load_o;
  logic       dp_step_o;
  logic       dp_op_o;
  logic       stall_o;
  logic       rf_we_o;
  logic [4:0] rf_addr_o;
  logic       rf_sel_mdu_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;

  mdu_sequencer #(.ITER(32), .MAX_WAIT(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .issue_valid_i(issue_valid_i), .issue_op_i(issue_op_i),
    .issue_rd_i(issue_rd_i), .hz_rs_i(hz_rs_i), .hz_rt_i(hz_rt_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .issue_ready_o(issue_ready_o), .dp_load_o(dp_load_o),
    .dp_step_o(dp_step_o), .dp_op_o(dp_op_o), .stall_o(stall_o),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o),
    .rf_sel_mdu_o(rf_sel_mdu_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic cyc;
    @(negedge clk_i);
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b0; start_i = 1'b1; issue_valid_i = 1'b1; issue_op_i = 1'b1;
    issue_rd_i = 5'd4; hz_rs_i = 5'd4; hz_rt_i = 5'd4;
    wb_valid_i = 1'b1; wb_rd_i = 5'd6;
    cyc(); settle();
    total++;
    if ({issue_ready_o, dp_load_o, dp_step_o, dp_op_o, stall_o, rf_we_o,
         rf_sel_mdu_o, busy_o} !== 8'b0 || rf_addr_o !== 5'd0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b ld=%b st=%b op=%b stall=%b we=%b addr=%0d sel=%b busy=%b want all 0",
               issue_ready_o, dp_load_o, dp_step_o, dp_op_o, stall_o, rf_we_o,
               rf_addr_o, rf_sel_mdu_o, busy_o);
    end
    issue_valid_i = 1'b0; wb_valid_i = 1'b0; hz_rs_i = 5'd0; hz_rt_i = 5'd0;
    cyc(); rst_i = 1'b1; settle();
    total++;
    if (issue_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got rdy=%b busy=%b want rdy=1 busy=0", issue_ready_o, busy_o);
    end
  endtask

  task automatic test_mul;
    int steps = 0;
    int bad_step = 0;
    cyc(); issue_valid_i = 1'b1; issue_op_i = 1'b0; issue_rd_i = 5'd8; settle();
    total++;
    if (issue_ready_o !== 1'b1) begin
      bad++; $display("FAIL mul_ready got %b want 1", issue_ready_o);
    end
    cyc(); issue_valid_i = 1'b0; settle();
    total++;
    if (dp_load_o !== 1'b1 || dp_step_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL mul_load got ld=%b st=%b busy=%b want 1 0 1", dp_load_o, dp_step_o, busy_o);
    end
    for (int i = 0; i < 32; i++) begin
      cyc(); settle();
      if (dp_step_o === 1'b1) steps++;
      if (dp_op_o !== 1'b0 || dp_load_o !== 1'b0 || rf_sel_mdu_o !== 1'b0) bad_step++;
    end
    total++;
    if (steps != 32 || bad_step != 0) begin
      bad++; $display("FAIL mul_steps got steps=%0d badcyc=%0d want 32 0", steps, bad_step);
    end
    cyc(); settle();
    total++;
    if (dp_step_o !== 1'b0 || rf_we_o !== 1'b1 || rf_addr_o !== 5'd8 ||
        rf_sel_mdu_o !== 1'b1 || stall_o !== 1'b0) begin
      bad++; $display("FAIL mul_write got st=%b we=%b addr=%0d sel=%b stall=%b want 0 1 8 1 0",
                      dp_step_o, rf_we_o, rf_addr_o, rf_sel_mdu_o, stall_o);
    end
    cyc(); settle();
    total++;
    if (busy_o !== 1'b0 || rf_we_o !== 1'b0 || issue_ready_o !== 1'b1) begin
      bad++; $display("FAIL mul_idle got busy=%b we=%b rdy=%b want 0 0 1", busy_o, rf_we_o, issue_ready_o);
    end
  endtask

  task automatic test_div_wait;
    int bad_op = 0;
    cyc(); issue_valid_i = 1'b1; issue_op_i = 1'b1; issue_rd_i = 5'd9; settle();
    cyc(); issue_valid_i = 1'b0; issue_op_i = 1'b0; settle();
    for (int i = 0; i < 32; i++) begin
      cyc(); settle();
      if (dp_op_o !== 1'b1 || dp_step_o !== 1'b1) bad_op++;
    end
    total++;
    if (bad_op != 0) begin
      bad++; $display("FAIL div_op bad cycles got %0d want 0", bad_op);
    end
    for (int g = 0; g < 2; g++) begin
      cyc(); wb_valid_i = 1'b1; wb_rd_i = 5'd3; settle();
      total++;
      if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd3 || rf_sel_mdu_o !== 1'b0 ||
          stall_o !== 1'b0 || busy_o !== 1'b1) begin
        bad++; $display("FAIL div_yield%0d got we=%b addr=%0d sel=%b stall=%b busy=%b want 1 3 0 0 1",
                        g, rf_we_o, rf_addr_o, rf_sel_mdu_o, stall_o, busy_o);
      end
    end
    cyc(); settle();
    total++;
    if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd9 || rf_sel_mdu_o !== 1'b1 || stall_o !== 1'b1) begin
      bad++; $display("FAIL div_forced got we=%b addr=%0d sel=%b stall=%b want 1 9 1 1",
                      rf_we_o, rf_addr_o, rf_sel_mdu_o, stall_o);
    end
    cyc(); settle();
    total++;
    if (busy_o !== 1'b0 || rf_addr_o !== 5'd3 || rf_sel_mdu_o !== 1'b0 || stall_o !== 1'b0) begin
      bad++; $display("FAIL div_after got busy=%b addr=%0d sel=%b stall=%b want 0 3 0 0",
                      busy_o, rf_addr_o, rf_sel_mdu_o, stall_o);
    end
    wb_valid_i = 1'b0; wb_rd_i = 5'd0;
  endtask

  task automatic test_raw;
    int miss = 0;
    cyc(); issue_valid_i = 1'b1; issue_rd_i = 5'd10; settle();
    cyc(); issue_valid_i = 1'b0; hz_rs_i = 5'd10; hz_rt_i = 5'd1; settle();
    if (stall_o !== 1'b1) miss++;
    for (int i = 0; i < 32; i++) begin
      cyc(); settle();
      if (stall_o !== 1'b1) miss++;
    end
    total++;
    if (miss != 0) begin
      bad++; $display("FAIL raw_stall missing in %0d cycles want 0", miss);
    end
    cyc(); settle();
    total++;
    if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd10 || rf_sel_mdu_o !== 1'b1) begin
      bad++; $display("FAIL raw_write got we=%b addr=%0d sel=%b want 1 10 1", rf_we_o, rf_addr_o, rf_sel_mdu_o);
    end
    cyc(); settle();
    total++;
    if (stall_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL raw_clear got stall=%b busy=%b want 0 0", stall_o, busy_o);
    end
    // rt match alone also counts as a hazard
    cyc(); hz_rs_i = 5'd0; hz_rt_i = 5'd0; issue_valid_i = 1'b1; issue_rd_i = 5'd17; settle();
    cyc(); issue_valid_i = 1'b0; hz_rt_i = 5'd17; settle();
    total++;
    if (stall_o !== 1'b1) begin
      bad++; $display("FAIL raw_rt got stall=%b want 1", stall_o);
    end
    cyc(); hz_rt_i = 5'd16; settle();
    total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL raw_nomatch got stall=%b want 0", stall_o);
    end
    hz_rt_i = 5'd0;
    for (int i = 0; i < 33; i++) cyc();
    settle();
    total++;
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL raw_rt_done got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_rd0;
    int steps = 0;
    int viol = 0;
    cyc(); issue_valid_i = 1'b1; issue_rd_i = 5'd0; hz_rs_i = 5'd0; settle();
    cyc(); issue_valid_i = 1'b0; settle();
    for (int i = 0; i < 34; i++) begin
      if (dp_step_o === 1'b1) steps++;
      if (rf_we_o !== 1'b0 || stall_o !== 1'b0) viol++;
      cyc(); settle();
    end
    total++;
    if (steps != 32 || viol != 0) begin
      bad++; $display("FAIL rd0 got steps=%0d viol=%0d want 32 0", steps, viol);
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL rd0_idle got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_back_to_back;
    int viol = 0;
    cyc(); issue_valid_i = 1'b1; issue_rd_i = 5'd11; settle();
    cyc(); issue_rd_i = 5'd12; settle();
    for (int i = 0; i < 34; i++) begin
      if (stall_o !== 1'b1 || issue_ready_o !== 1'b0) viol++;
      cyc(); settle();
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL b2b_hold got viol=%0d want 0", viol);
    end
    total++;
    if (issue_ready_o !== 1'b1 || stall_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL b2b_accept got rdy=%b stall=%b busy=%b want 1 0 0", issue_ready_o, stall_o, busy_o);
    end
    cyc(); issue_valid_i = 1'b0; settle();
    total++;
    if (dp_load_o !== 1'b1) begin
      bad++; $display("FAIL b2b_load got %b want 1", dp_load_o);
    end
    for (int i = 0; i < 33; i++) cyc();
    settle();
    total++;
    if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd12 || rf_sel_mdu_o !== 1'b1) begin
      bad++; $display("FAIL b2b_write got we=%b addr=%0d sel=%b want 1 12 1", rf_we_o, rf_addr_o, rf_sel_mdu_o);
    end
    cyc(); settle();
  endtask

  task automatic test_start_fall;
    cyc(); issue_valid_i = 1'b1; issue_rd_i = 5'd5; settle();
    cyc(); issue_valid_i = 1'b0; start_i = 1'b0; settle();
    for (int i = 0; i < 33; i++) cyc();
    settle();
    total++;
    if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd5 || rf_sel_mdu_o !== 1'b1) begin
      bad++; $display("FAIL startfall_write got we=%b addr=%0d sel=%b want 1 5 1", rf_we_o, rf_addr_o, rf_sel_mdu_o);
    end
    cyc(); issue_valid_i = 1'b1; issue_rd_i = 5'd6; settle();
    total++;
    if (issue_ready_o !== 1'b0) begin
      bad++; $display("FAIL startfall_ready got %b want 0", issue_ready_o);
    end
    cyc(); settle();
    total++;
    if (dp_load_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL startfall_noissue got ld=%b busy=%b want 0 0", dp_load_o, busy_o);
    end
    issue_valid_i = 1'b0; start_i = 1'b1;
  endtask

  task automatic test_reset_mid;
    int steps = 0;
    cyc(); issue_valid_i = 1'b1; issue_rd_i = 5'd7; settle();
    cyc(); issue_valid_i = 1'b0; settle();
    for (int i = 0; i < 9; i++) cyc();
    rst_i = 1'b0; settle();
    total++;
    if (dp_step_o !== 1'b0 || busy_o !== 1'b0 || issue_ready_o !== 1'b0) begin
      bad++; $display("FAIL midreset got st=%b busy=%b rdy=%b want 0 0 0", dp_step_o, busy_o, issue_ready_o);
    end
    cyc(); rst_i = 1'b1; settle();
    cyc(); issue_valid_i = 1'b1; issue_rd_i = 5'd13; settle();
    cyc(); issue_valid_i = 1'b0; settle();
    total++;
    if (dp_load_o !== 1'b1) begin
      bad++; $display("FAIL midreset_load got %b want 1", dp_load_o);
    end
    for (int i = 0; i < 32; i++) begin
      cyc(); settle();
      if (dp_step_o === 1'b1) steps++;
    end
    cyc(); settle();
    total++;
    if (steps != 32 || rf_addr_o !== 5'd13 || rf_sel_mdu_o !== 1'b1) begin
      bad++; $display("FAIL midreset_rerun got steps=%0d addr=%0d sel=%b want 32 13 1", steps, rf_addr_o, rf_sel_mdu_o);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_wait();
    test_raw();
    test_rd0();
    test_back_to_back();
    test_start_fall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
